// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder
// Clause 22 MDIO PHY-side responder with a 32x16 register file.
// mdc and mdio_i are synchronised into clk_int. Frames are decoded on mdc
// rises. Read data is driven on mdc falls.
// Frame bit index: ST=0..1, OP=2..3, PHYAD=4..8, REGAD=9..13, TA=14..15,
// DATA=16..31.

module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR   = 5'd1,
    parameter logic [15:0] PHY_ID1    = 16'h001C,
    parameter logic [15:0] PHY_ID2    = 16'hC915,
    parameter logic [15:0] PHY_STATUS = 16'h796D,
    parameter logic [15:0] BMCR_RST   = 16'h1140
) (
    input  logic        clk_int,
    input  logic        rst_int,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    output logic        loopback,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic [7:0]  frame_err
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ST    = 4'd1,
        ST_OP    = 4'd2,
        ST_PHYAD = 4'd3,
        ST_REGAD = 4'd4,
        ST_TA1   = 4'd5,
        ST_TA2   = 4'd6,
        ST_RDATA = 4'd7,
        ST_WTA   = 4'd8,
        ST_WDATA = 4'd9,
        ST_SKIP  = 4'd10
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        mdc_meta_r, mdc_sync_r, mdc_prev_r;
    logic        mdio_meta_r, mdio_sync_r;
    logic        rise_s, fall_s, bit_s;
    logic [5:0]  pre_cnt_r;
    logic        pre_full_s;
    logic [5:0]  bit_idx_r;
    logic [14:0] shift_r;
    logic        is_read_r;
    logic        phy_match_r;
    logic [4:0]  regad_r;
    logic [15:0] rd_shift_r;
    logic [15:0] regs_r [32];
    logic [15:0] wdata_s;
    logic        start_s, err_s, wr_evt_s, rd_latch_s;
    logic        drv_start_s, drv_bit_s, drv_stop_s;

    // Register read view: ID/status are constants, the BMCR reset bit always reads 0.
    function automatic logic [15:0] rd_mux(input logic [4:0] addr, input logic [15:0] val);
        logic [15:0] r;
        case (addr)
            5'd0:    r = val & 16'h7FFF;
            5'd1:    r = PHY_STATUS;
            5'd2:    r = PHY_ID1;
            5'd3:    r = PHY_ID2;
            default: r = val;
        endcase
        return r;
    endfunction

    assign rise_s     = mdc_sync_r & ~mdc_prev_r;
    assign fall_s     = ~mdc_sync_r & mdc_prev_r;
    assign bit_s      = mdio_sync_r;
    assign pre_full_s = (pre_cnt_r == 6'd32);
    assign wdata_s    = {shift_r, bit_s};
    assign loopback   = regs_r[0][14];

    // Two-flop synchronisers for mdc and mdio, plus the previous mdc for edge detection.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            mdc_meta_r  <= 1'b0;
            mdc_sync_r  <= 1'b0;
            mdc_prev_r  <= 1'b0;
            mdio_meta_r <= 1'b0;
            mdio_sync_r <= 1'b0;
        end else begin
            mdc_meta_r  <= mdc;
            mdc_sync_r  <= mdc_meta_r;
            mdc_prev_r  <= mdc_sync_r;
            mdio_meta_r <= mdio_i;
            mdio_sync_r <= mdio_meta_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and single-cycle event strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        err_s       = 1'b0;
        wr_evt_s    = 1'b0;
        rd_latch_s  = 1'b0;
        drv_start_s = 1'b0;
        drv_bit_s   = 1'b0;
        drv_stop_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s && !bit_s && pre_full_s) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_ST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ST: begin
                if (rise_s) begin
                    if (bit_s) begin
                        state_nxt_s = ST_OP;
                    end else begin
                        err_s       = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ST;
                end
            end
            ST_OP: begin
                if (rise_s && bit_idx_r == 6'd3) begin
                    case ({shift_r[0], bit_s})
                        2'b10, 2'b01: state_nxt_s = ST_PHYAD;
                        default: begin
                            err_s       = 1'b1;
                            state_nxt_s = ST_SKIP;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_OP;
                end
            end
            ST_PHYAD: begin
                if (rise_s && bit_idx_r == 6'd8) begin
                    state_nxt_s = ST_REGAD;
                end else begin
                    state_nxt_s = ST_PHYAD;
                end
            end
            ST_REGAD: begin
                if (rise_s && bit_idx_r == 6'd13) begin
                    if (!phy_match_r) begin
                        state_nxt_s = ST_SKIP;
                    end else if (is_read_r) begin
                        state_nxt_s = ST_TA1;
                    end else begin
                        state_nxt_s = ST_WTA;
                    end
                end else begin
                    state_nxt_s = ST_REGAD;
                end
            end
            ST_TA1: begin
                if (rise_s) begin
                    rd_latch_s  = 1'b1;
                    state_nxt_s = ST_TA2;
                end else begin
                    state_nxt_s = ST_TA1;
                end
            end
            ST_TA2: begin
                if (fall_s) begin
                    drv_start_s = 1'b1;
                    state_nxt_s = ST_RDATA;
                end else begin
                    state_nxt_s = ST_TA2;
                end
            end
            ST_RDATA: begin
                if (fall_s) begin
                    if (bit_idx_r == 6'd32) begin
                        drv_stop_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        drv_bit_s   = 1'b1;
                        state_nxt_s = ST_RDATA;
                    end
                end else begin
                    state_nxt_s = ST_RDATA;
                end
            end
            ST_WTA: begin
                if (rise_s && bit_idx_r == 6'd15) begin
                    if ({shift_r[0], bit_s} == 2'b10) begin
                        state_nxt_s = ST_WDATA;
                    end else begin
                        err_s       = 1'b1;
                        state_nxt_s = ST_SKIP;
                    end
                end else begin
                    state_nxt_s = ST_WTA;
                end
            end
            ST_WDATA: begin
                if (rise_s && bit_idx_r == 6'd31) begin
                    wr_evt_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WDATA;
                end
            end
            ST_SKIP: begin
                if (rise_s && bit_idx_r == 6'd31) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SKIP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Preamble counter: consecutive ones seen in IDLE, saturating at 32.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            pre_cnt_r <= 6'd0;
        end else if (state_r != ST_IDLE) begin
            pre_cnt_r <= 6'd0;
        end else if (rise_s) begin
            if (!bit_s) begin
                pre_cnt_r <= 6'd0;
            end else if (!pre_full_s) begin
                pre_cnt_r <= pre_cnt_r + 6'd1;
            end else begin
                pre_cnt_r <= pre_cnt_r;
            end
        end else begin
            pre_cnt_r <= pre_cnt_r;
        end
    end

    // Frame bit index (the ST zero is bit 0), shift register and field captures.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            bit_idx_r   <= 6'd0;
            shift_r     <= 15'd0;
            is_read_r   <= 1'b0;
            phy_match_r <= 1'b0;
            regad_r     <= 5'd0;
        end else begin
            if (start_s) begin
                bit_idx_r <= 6'd1;
            end else if (state_r == ST_IDLE) begin
                bit_idx_r <= 6'd0;
            end else if (rise_s) begin
                bit_idx_r <= bit_idx_r + 6'd1;
            end
            if (rise_s) begin
                shift_r <= {shift_r[13:0], bit_s};
            end
            if (state_r == ST_OP && rise_s && bit_idx_r == 6'd3) begin
                is_read_r <= shift_r[0] & ~bit_s;
            end
            if (state_r == ST_PHYAD && rise_s && bit_idx_r == 6'd8) begin
                phy_match_r <= ({shift_r[3:0], bit_s} == PHY_ADDR);
            end
            if (state_r == ST_REGAD && rise_s && bit_idx_r == 6'd13) begin
                regad_r <= {shift_r[3:0], bit_s};
            end
        end
    end

    // Read path: latch read data at TA1, drive TA2 zero then data MSB first on falls.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            rd_shift_r <= 16'h0000;
            mdio_o     <= 1'b0;
            mdio_oe    <= 1'b0;
        end else if (rd_latch_s) begin
            rd_shift_r <= rd_mux(regad_r, regs_r[regad_r]);
        end else if (drv_start_s) begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b0;
        end else if (drv_bit_s) begin
            mdio_o     <= rd_shift_r[15];
            rd_shift_r <= {rd_shift_r[14:0], 1'b0};
        end else if (drv_stop_s || state_r != ST_RDATA) begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b0;
        end
    end

    // Register file writes, write report outputs and the saturating error count.
    always_ff @(posedge clk_int or posedge rst_int) begin
        if (rst_int) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 16'h0000;
            end
            regs_r[0] <= BMCR_RST;
            wr_strobe <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 16'h0000;
            frame_err <= 8'd0;
        end else begin
            wr_strobe <= wr_evt_s;
            if (wr_evt_s) begin
                wr_addr <= regad_r;
                wr_data <= wdata_s;
                case (regad_r)
                    5'd0: begin
                        if (wdata_s[15]) begin
                            for (int i = 0; i < 32; i++) begin
                                regs_r[i] <= 16'h0000;
                            end
                            regs_r[0] <= BMCR_RST;
                        end else begin
                            regs_r[0] <= wdata_s;
                        end
                    end
                    5'd1, 5'd2, 5'd3: begin
                        regs_r[0] <= regs_r[0];
                    end
                    default: regs_r[regad_r] <= wdata_s;
                endcase
            end
            if (err_s && frame_err != 8'hFF) begin
                frame_err <= frame_err + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder
// Bit-bangs Clause 22 frames into mdio_phy_responder. A table of frames gives
// the expected read data, write reports, error count and loopback state. Read
// data is queued when a frame is issued and popped when the responder drives it.

module tb_mdio_phy_responder;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        exp_oe;
        logic [15:0] exp_rd;
        logic        exp_stb;
        logic        exp_lb;
    } vec_t;

    localparam int NV = 17;

    logic        clk_int = 1'b0;
    logic        rst_int;
    logic        mdc;
    logic        m_drv;
    logic        mdio_line;
    logic        mdio_o;
    logic        mdio_oe;
    logic        loopback;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  frame_err;

    int          total = 0;
    int          bad = 0;
    int          oe_cnt = 0;
    int          stb_cnt = 0;
    int          cur_id = 0;
    int          half_cyc = 6;
    logic [15:0] exp_q [$];
    vec_t        vecs [NV];

    assign mdio_line = mdio_oe ? mdio_o : m_drv;

    always #4 clk_int = ~clk_int;

    mdio_phy_responder dut (
        .clk_int   (clk_int),
        .rst_int   (rst_int),
        .mdc       (mdc),
        .mdio_i    (mdio_line),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .loopback  (loopback),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    // Count clocks with the responder driving and clocks with wr_strobe high.
    always @(posedge clk_int) begin
        if (mdio_oe) oe_cnt <= oe_cnt + 1;
        if (wr_strobe) stb_cnt <= stb_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s (frame %0d): got %h want %h", nm, cur_id, act, req);
        end
    endtask

    // One mdc period: drive during low phase, sample line and oe at the rise.
    task automatic mbit(input logic b, output logic smp, output logic oe_smp);
        m_drv = b;
        repeat (half_cyc) @(posedge clk_int);
        #1;
        mdc    = 1'b1;
        smp    = mdio_line;
        oe_smp = mdio_oe;
        repeat (half_cyc) @(posedge clk_int);
        #1;
        mdc = 1'b0;
    endtask

    task automatic run_frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [1:0] ta,
                             input logic [15:0] wdata, output logic [15:0] rdata,
                             output logic oe_ta1, output logic oe_ta2, output logic bit_ta2);
        logic s, o;
        rdata = 16'h0000; oe_ta1 = 1'b0; oe_ta2 = 1'b0; bit_ta2 = 1'b1;
        for (int i = 0; i < pre_len; i++) mbit(1'b1, s, o);
        mbit(1'b0, s, o);
        mbit(1'b1, s, o);
        for (int i = 1; i >= 0; i--) mbit(op[i], s, o);
        for (int i = 4; i >= 0; i--) mbit(phy[i], s, o);
        for (int i = 4; i >= 0; i--) mbit(regad[i], s, o);
        if (op == 2'b10) begin
            mbit(1'b1, s, oe_ta1);
            mbit(1'b1, bit_ta2, oe_ta2);
            for (int i = 15; i >= 0; i--) begin
                mbit(1'b1, s, o);
                rdata[i] = s;
            end
        end else begin
            mbit(ta[1], s, o);
            mbit(ta[0], s, o);
            for (int i = 15; i >= 0; i--) mbit(wdata[i], s, o);
        end
        m_drv = 1'b1;
        repeat (half_cyc) @(posedge clk_int);
        #1;
    endtask

    // Issue one frame and check drive window, read data, write report, errors, loopback.
    task automatic xact(input vec_t v, input int pre_len, input logic [1:0] ta,
                        input logic [7:0] exp_err);
        int          oe0, stb0;
        logic [15:0] rd, e;
        logic        t1, t2, tb;
        oe0  = oe_cnt;
        stb0 = stb_cnt;
        if (v.exp_oe) exp_q.push_back(v.exp_rd);
        run_frame(pre_len, v.op, v.phy, v.regad, ta, v.wdata, rd, t1, t2, tb);
        chk("oe_seen", 32'(oe_cnt != oe0), 32'(v.exp_oe));
        if (oe_cnt != oe0) begin
            chk("ta1_oe", 32'(t1), 32'd0);
            chk("ta2_oe", 32'(t2), 32'd1);
            chk("ta2_bit", 32'(tb), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow (frame %0d): got drive want none", cur_id);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", 32'(rd), 32'(e));
            end
        end else if (v.exp_oe && exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
        chk("oe_released", 32'(mdio_oe), 32'd0);
        chk("strobe_clks", 32'(stb_cnt - stb0), 32'(v.exp_stb));
        if (v.exp_stb) begin
            chk("wr_addr", 32'(wr_addr), 32'(v.regad));
            chk("wr_data", 32'(wr_data), 32'(v.wdata));
        end
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("loopback", 32'(loopback), 32'(v.exp_lb));
        cur_id++;
    endtask

    initial begin
        vec_t h;
        logic s, o;
        //          op     phy    reg     wdata     oe    rd        stb   lb
        vecs[0]  = '{2'b10, 5'd1, 5'd2,  16'h0000, 1'b1, 16'h001C, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 5'd1, 5'd4,  16'h01E1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{2'b10, 5'd1, 5'd4,  16'h0000, 1'b1, 16'h01E1, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 5'd1, 5'd1,  16'h0000, 1'b1, 16'h796D, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 5'd1, 5'd0,  16'h4140, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{2'b10, 5'd1, 5'd0,  16'h0000, 1'b1, 16'h4140, 1'b0, 1'b1};
        vecs[6]  = '{2'b01, 5'd1, 5'd0,  16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{2'b10, 5'd1, 5'd0,  16'h0000, 1'b1, 16'h1140, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 5'd1, 5'd4,  16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 5'd2, 5'd3,  16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 5'd1, 5'd3,  16'h0000, 1'b1, 16'hC915, 1'b0, 1'b0};
        vecs[11] = '{2'b01, 5'd1, 5'd2,  16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{2'b10, 5'd1, 5'd2,  16'h0000, 1'b1, 16'h001C, 1'b0, 1'b0};
        vecs[13] = '{2'b01, 5'd1, 5'd31, 16'hA5A5, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[14] = '{2'b10, 5'd1, 5'd31, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0};
        vecs[15] = '{2'b01, 5'd3, 5'd5,  16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[16] = '{2'b10, 5'd1, 5'd5,  16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};

        rst_int = 1'b1;
        mdc     = 1'b0;
        m_drv   = 1'b1;
        repeat (5) @(posedge clk_int);
        #1;
        chk("rst_oe", 32'(mdio_oe), 32'd0);
        chk("rst_o", 32'(mdio_o), 32'd0);
        chk("rst_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_loopback", 32'(loopback), 32'd0);
        rst_int = 1'b0;
        repeat (3) @(posedge clk_int);
        #1;

        for (int k = 0; k < NV; k++) begin
            xact(vecs[k], 32, 2'b10, 8'd0);
        end

        // 31-bit preamble: frame ignored, not an error.
        h = '{2'b10, 5'd1, 5'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        xact(h, 31, 2'b10, 8'd0);
        // OP=11: counted as an error, skipped, never driven.
        h = '{2'b11, 5'd1, 5'd2, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        xact(h, 32, 2'b10, 8'd1);
        // Write with TA=11: error, no write.
        h = '{2'b01, 5'd1, 5'd6, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        xact(h, 32, 2'b11, 8'd2);
        h = '{2'b10, 5'd1, 5'd6, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
        xact(h, 32, 2'b10, 8'd2);
        // Good write to reg 7, later wiped by reset.
        h = '{2'b01, 5'd1, 5'd7, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
        xact(h, 32, 2'b10, 8'd2);

        // Reset in the middle of RDATA bit 5 of a read of reg 7.
        for (int i = 0; i < 32; i++) mbit(1'b1, s, o);
        mbit(1'b0, s, o);
        mbit(1'b1, s, o);
        mbit(1'b1, s, o);
        mbit(1'b0, s, o);
        for (int i = 4; i >= 0; i--) mbit(((i == 0) ? 1'b1 : 1'b0), s, o);
        for (int i = 4; i >= 0; i--) mbit(((i <= 2) ? 1'b1 : 1'b0), s, o);
        mbit(1'b1, s, o);
        mbit(1'b1, s, o);
        for (int i = 0; i < 5; i++) mbit(1'b1, s, o);
        m_drv = 1'b1;
        repeat (half_cyc) @(posedge clk_int);
        #2;
        chk("oe_before_rst", 32'(mdio_oe), 32'd1);
        rst_int = 1'b1;
        #1;
        chk("oe_async_rst", 32'(mdio_oe), 32'd0);
        repeat (3) @(posedge clk_int);
        #1;
        rst_int = 1'b0;
        repeat (3) @(posedge clk_int);
        #1;
        chk("frame_err_after_rst", 32'(frame_err), 32'd0);
        h = '{2'b10, 5'd1, 5'd0, 16'h0000, 1'b1, 16'h1140, 1'b0, 1'b0};
        xact(h, 32, 2'b10, 8'd0);
        h = '{2'b10, 5'd1, 5'd7, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0};
        xact(h, 32, 2'b10, 8'd0);

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
- Synthesizable IEEE 802.3 Clause 22 MDIO management responder, i.e. the PHY end of the software bit-banged MDIO master in the Ethernet framing block.
- Sits on phy_mdc/phy_mdio in loopback and simulation builds in place of the external RGMII PHY.
- Holds a 32x16 PHY register file: read-only IDs/status, plus RW control registers.
- Lets driver MDIO code and the tri-state wiring be exercised without silicon.

Parameters:
PHY_ADDR, 5'd1, PHY address this responder answers to
PHY_ID1, 16'h001C, read-only value of reg 2
PHY_ID2, 16'hC915, read-only value of reg 3
PHY_STATUS, 16'h796D, read-only value of reg 1
BMCR_RST, 16'h1140, reset/default value of reg 0

Ports:
clk_int  input  1  system clock (125 MHz)
rst_int  input  1  asynchronous reset, active-high
mdc  input  1  management clock from master, asynchronous to clk_int
mdio_i  input  1  MDIO line as driven by master
mdio_o  output  1  responder MDIO drive value
mdio_oe  output  1  responder MDIO output enable
loopback  output  1  reg0 bit 14
wr_strobe  output  1  one-clk pulse on a completed write to this PHY
wr_addr  output  5  register address of the last write
wr_data  output  16  data of the last write
frame_err  output  8  saturating count of aborted or invalid frames

Behaviour:
- Reset values (async): all outputs 0; mdio_oe=0; regfile all 0 except reg0=BMCR_RST; state IDLE.
- Synchronisation: mdc and mdio_i each pass through 2 flops.
  - An mdc rise or fall is detected from the synchronised mdc and its previous value.
  - Input samples are taken on detected rises, using synchronised mdio.
  - Required: mdc high and low each >=4 clk_int cycles.
- Drive timing: mdio_o/mdio_oe change only on the clk_int cycle a fall is detected. Edge-to-drive latency is 3 clk_int.
- Serial order: MSB first for PHYAD, REGAD and DATA.
- IDLE: count consecutive 1 samples, saturating at 32. Any 0 with count<32 clears the count.
  - A 0 with count>=32 is ST bit0; go to ST.
- ST: expect 1. On 0, frame_err++ and return to IDLE with count 0.
- OP: 2 bits. 10 = read, 01 = write. 00/11: frame_err++ and go to SKIP.
- PHYAD: 5 bits. REGAD: 5 bits. If PHYAD != PHY_ADDR, go to SKIP after REGAD. This is not an error.
- Read turnaround (TA):
  - First TA rise: latch rdata = reg[REGAD]; oe stays 0.
  - Next fall: oe=1, mdio_o=0.
- RDATA: on each fall after that, present the next data bit. After the fall that follows the 16th data rise, set oe=0 and go to IDLE.
- Write turnaround: sample TA as 2 bits, expect 10. Mismatch: frame_err++ and go to SKIP. Otherwise go to WDATA.
- WDATA: shift 16 bits. On the 16th rise:
  - regs 1/2/3: discard data.
  - reg 0 with bit 15 set: restore the whole regfile to reset defaults; bit 15 reads back 0 (self-clearing).
  - other regs: store the data.
  - In all cases, pulse wr_strobe for 1 clk and update wr_addr/wr_data.
  - Then go to IDLE.
- SKIP: oe=0. Count rises to the end of the 32-bit frame (the count starts at ST), then go to IDLE with preamble count 0.
- Regs 1/2/3 always read their parameters. Reg0 bit 15 always reads 0.
- 32 ones in any state other than IDLE: no abort; the frame structure rules.
- Reset mid-frame: oe drops immediately; the frame is lost.
- frame_err saturates at 8'hFF.
- The responder never drives oe while the master owns the line, i.e. outside the TA2/RDATA window.

Test Plan:
- Preamble 32x1, then read PHYAD=1 REGAD=2 -> oe rises at the TA2 fall, TA2 bit=0, data 16'h001C, oe low after the 16th bit; frame_err=0.
- Write PHYAD=1 REGAD=4 data 16'h01E1, then read reg 4 -> wr_strobe one pulse with wr_addr=4 and wr_data=16'h01E1; readback 16'h01E1.
- Write reg0=16'h4140 -> loopback=1. Then write reg0=16'h8000 -> regfile reset, loopback=0, reg0 reads 16'h1140, reg4 reads 0.
- Read with PHYAD=2 -> mdio_oe never asserts. The next frame (preamble plus a read of reg 3 at PHYAD=1) returns 16'hC915.
- Only 31-bit preamble before the read -> no response, frame_err=0. Then OP=11 after a 32-bit preamble -> frame_err=1, no drive.
- Assert rst_int during RDATA bit 5 -> mdio_oe=0 asynchronously; after reset, a read of reg0 returns 16'h1140.
